// File: rtl/cic_comp_fir.sv
// cic_comp_fir: CIC compensation FIR with runtime-loadable taps, one shared multiplier,
// and round-half-up / saturate to OUT_WIDTH.
module cic_comp_fir #(
    parameter int IN_WIDTH   = 18,
    parameter int OUT_WIDTH  = 16,
    parameter int TAPS       = 7,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int SHIFT      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IN_WIDTH-1:0]      input_tdata,
    input  logic                     input_tvalid,
    output logic                     input_tready,
    output logic [OUT_WIDTH-1:0]     output_tdata,
    output logic                     output_tvalid,
    input  logic                     output_tready,
    output logic                     output_sat,
    input  logic                     coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_WIDTH-1:0]    coef_data,
    output logic                     coef_busy
);
    localparam int AW = $clog2(TAPS);
    localparam int ACC_W = IN_WIDTH + COEF_WIDTH + AW;
    localparam int SH = COEF_FRAC + SHIFT;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SH - 1);
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OMIN = -OMAX - 1;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;
    state_t state, state_nx;

    logic signed [IN_WIDTH-1:0]   d    [TAPS];
    logic signed [COEF_WIDTH-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]      acc, prod, rnd;
    logic [AW-1:0]                tap;
    logic                         take, last, hi, lo, sat_q;

    assign input_tready  = state == IDLE;
    assign coef_busy     = state != IDLE;
    assign output_tvalid = state == OUT;
    assign output_sat    = sat_q && output_tvalid;
    assign take = input_tvalid && input_tready;
    assign last = tap == AW'(TAPS - 1);
    assign prod = ACC_W'(d[tap]) * ACC_W'(coef[tap]);
    assign rnd  = (acc + HALF) >>> SH;
    assign hi   = rnd > OMAX;
    assign lo   = rnd < OMIN;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = take ? MAC : IDLE;
            MAC:     state_nx = last ? ROUND : MAC;
            ROUND:   state_nx = OUT;
            OUT:     state_nx = output_tready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            tap          <= '0;
            output_tdata <= '0;
            sat_q        <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                d[i]    <= '0;
                coef[i] <= (i == (TAPS - 1) / 2) ? COEF_WIDTH'(1 << COEF_FRAC) : '0;
            end
        end else begin
            state <= state_nx;
            if (take) begin
                d[0] <= $signed(input_tdata);
                for (int i = 1; i < TAPS; i++)
                    d[i] <= d[i-1];
                acc <= '0;
                tap <= '0;
            end
            if (state == MAC) begin
                acc <= acc + prod;
                tap <= tap + 1'b1;
            end
            if (state == ROUND) begin
                output_tdata <= hi ? OUT_WIDTH'(OMAX) : lo ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(rnd);
                sat_q        <= hi | lo;
            end
            // Idle-only writes: a write coinciding with the handshake lands before MAC reads it
            if (coef_wr_en && !coef_busy && coef_addr < AW'(TAPS))
                coef[coef_addr] <= $signed(coef_data);
        end
    end
endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Symmetric-response CIC compensation FIR placed directly downstream of the CIC decimator.
- Consumes the decimator's full-width signed AXI-stream samples and applies a runtime-loadable TAPS-tap FIR using one time-multiplexed multiplier.
- Rounds, scales and saturates each result to OUT_WIDTH for the next stage.
- Its input rate is low (decimated), so a multi-cycle MAC per sample is acceptable.

Parameters:
- IN_WIDTH, 18, signed input sample width; equals the decimator output width.
- OUT_WIDTH, 16, signed output width.
- TAPS, 7, number of taps; must be odd and >= 3.
- COEF_WIDTH, 16, signed coefficient width.
- COEF_FRAC, 14, fractional bits of the coefficients; 1<<COEF_FRAC is unity.
- SHIFT, 2, extra right shift after removing COEF_FRAC; normally IN_WIDTH-OUT_WIDTH.

Ports:
- clk, input, 1, clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- input_tdata, input, IN_WIDTH, signed sample.
- input_tvalid, input, 1, sample valid.
- input_tready, output, 1, high only in state IDLE.
- output_tdata, output, OUT_WIDTH, filtered sample (registered).
- output_tvalid, output, 1, high only in state OUT.
- output_tready, input, 1, downstream ready.
- output_sat, output, 1, high with output_tvalid when the current output was clipped.
- coef_wr_en, input, 1, coefficient write strobe.
- coef_addr, input, $clog2(TAPS), tap index.
- coef_data, input, COEF_WIDTH, signed coefficient.
- coef_busy, output, 1, high when state is not IDLE; writes are ignored while high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; delay line all 0; accumulator and tap counter 0.
  - output_tdata=0, output_tvalid=0, output_sat=0.
  - Coefficients: coef[(TAPS-1)/2] = 1<<COEF_FRAC, all others 0. Default filter is therefore a pure delay of (TAPS-1)/2 samples.
- Accumulator width: ACC_W = IN_WIDTH+COEF_WIDTH+$clog2(TAPS), signed. All products are signed IN_WIDTH x COEF_WIDTH, sign-extended to ACC_W.
- FSM states: IDLE, MAC, ROUND, OUT.
- IDLE:
  - input_tready=1.
  - On input_tvalid: shift the delay line (d[i+1]<=d[i], d[0]<=input_tdata), acc<=0, tap<=0, go to MAC.
- MAC:
  - Each cycle, acc += d[tap]*coef[tap] and tap increments.
  - Lasts exactly TAPS cycles; after tap==TAPS-1, go to ROUND.
- ROUND (1 cycle):
  - r = (acc + (1<<(COEF_FRAC+SHIFT-1))) >>> (COEF_FRAC+SHIFT). This is round-half-up with an arithmetic shift.
  - If r > 2^(OUT_WIDTH-1)-1 or r < -2^(OUT_WIDTH-1), clip to the limit and set output_sat=1; else output_sat=0.
  - Register the result into output_tdata; go to OUT.
- OUT:
  - output_tvalid=1; output_tdata and output_sat held stable.
  - On output_tready: go to IDLE.
- Latency: input handshake at cycle 0 gives output_tvalid at cycle TAPS+2.
- Minimum sample period is TAPS+3 cycles with output_tready held high. The upstream decimation ratio must be at least this, or input_tready applies backpressure.
- Backpressure: while OUT is stalled, input_tready=0 and no new sample is accepted. Delay line and coefficients are untouched.
- Coefficient writes:
  - Accepted only when coef_busy=0 and coef_addr<TAPS; take effect from the next sample.
  - coef_addr>=TAPS writes are dropped.
  - A write in the same cycle as an input handshake is accepted; the new coefficient is used for that sample's MAC.
- Reset asserted mid-MAC or mid-OUT aborts immediately to reset values; no partial output is emitted.
- After reset release, the first input handshake is accepted no earlier than the first clk edge with rst_n high.

Test Plan:
- Default coefficients, impulse: input 400 then six zeros → outputs 0,0,0,100,0,0,0. Each output_tvalid occurs 9 cycles after its input handshake; output_sat=0 throughout.
- Rounding/saturation, default coefficients:
  - Inputs 6, -6, 131071, -131072, three zeros → outputs 0,0,0,2,-1,32767,-32768.
  - output_sat=1 only on the 32767 output.
- Coefficient load: write all seven taps = 16384 while idle, then apply a step of 400 → outputs 100,200,...,700, then 700 steady.
- Coefficient write ignored: write coef[3]=0 while coef_busy=1 → has no effect. Also write coef_addr=7 → ignored. In both cases the impulse response is unchanged.
- Backpressure: hold output_tready=0 for 10 cycles while OUT → output_tdata and output_tvalid stable, input_tready=0, no sample lost. Then release → exactly one transfer and a return to IDLE.
- Reset mid-MAC: drop rst_n during MAC cycle 3 → output_tvalid=0 immediately, coefficients restored to default. The next impulse of 400 reproduces the first scenario.
